// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
//   Multi-entry architectural register store for the execute stage: one
//   synchronous write port (result writeback) and two independent
//   combinational read ports (operands A and B).
//
//   Parameters
//     BIT_WIDTH  : width of each stored word
//     NUM_REGS   : number of words (>= 2, need not be a power of two)
//     ZERO_REG   : 1 -> word 0 hardwired to zero, 0 -> ordinary register
//     ADDR_WIDTH : derived, $clog2(NUM_REGS)
//
//   Ports
//     clk      : clock, state updates on the rising edge
//     reset    : asynchronous active-high reset, clears every word
//     set      : write enable
//     waddr    : write address
//     in       : write data
//     raddr_a  : read port A address  -> out_a
//     raddr_b  : read port B address  -> out_b
//
//   Build option
//     REGISTER_FILE_BYPASS_EN : when defined, a read of the word being written
//     this cycle returns the write data combinationally (write-through).
//     Storage timing is the same in both builds.
// ----------------------------------------------------------------------------
module register_file #(
   parameter  int BIT_WIDTH  = 32,
   parameter  int NUM_REGS   = 32,
   parameter  int ZERO_REG   = 1,
   localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [BIT_WIDTH-1:0]  in,
   input  logic [ADDR_WIDTH-1:0] raddr_a,
   input  logic [ADDR_WIDTH-1:0] raddr_b,
   output logic [BIT_WIDTH-1:0]  out_a,
   output logic [BIT_WIDTH-1:0]  out_b
);

   logic [NUM_REGS-1:0]                we;
   logic                               wr_ok;
   logic [NUM_REGS-1:0][BIT_WIDTH-1:0] regs_q, regs_d;

   // Per-word write decode. Out-of-range addresses match no word, so those
   // writes fall away naturally; word 0 is never enabled when hardwired.
   always_comb begin
      we = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (set && (waddr == ADDR_WIDTH'(i)) && !((ZERO_REG != 0) && (i == 0)))
            we[i] = 1'b1;
      end
   end

   // A write will actually land this cycle (valid, writable address).
   assign wr_ok = |we;

   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (we[i]) regs_d[i] = in;
      end
   end

   // Async reset has priority, so a write on an edge during reset is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) regs_q <= '0;
      else       regs_q <= regs_d;
   end

   // Read mux by compare rather than array index: out-of-range addresses
   // select nothing and return 0, and a hardwired word 0 reads 0.
   function automatic logic [BIT_WIDTH-1:0] read_word(
      input logic [ADDR_WIDTH-1:0]          a,
      input logic [NUM_REGS-1:0][BIT_WIDTH-1:0] r
   );
      logic [BIT_WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if ((a == ADDR_WIDTH'(i)) && !((ZERO_REG != 0) && (i == 0)))
            v = r[i];
      end
      return v;
   endfunction

   always_comb begin
      out_a = read_word(raddr_a, regs_q);
      out_b = read_word(raddr_b, regs_q);
`ifdef REGISTER_FILE_BYPASS_EN
      // wr_ok already excludes invalid and hardwired-zero addresses.
      if (wr_ok && !reset && (raddr_a == waddr)) out_a = in;
      if (wr_ok && !reset && (raddr_b == waddr)) out_b = in;
`else
      // No bypass: the pending write is only visible after the edge.
`endif
   end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

   localparam int BW = 32;
   localparam int NR = 24;   // not a power of two: exercises out-of-range
   localparam int AW = 5;

   logic          clk;
   logic          reset;
   logic          set;
   logic [AW-1:0] waddr;
   logic [BW-1:0] in;
   logic [AW-1:0] raddr_a;
   logic [AW-1:0] raddr_b;
   logic [BW-1:0] out_a;
   logic [BW-1:0] out_b;

   register_file #(.BIT_WIDTH(BW), .NUM_REGS(NR), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset), .set(set), .waddr(waddr), .in(in),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .out_a(out_a), .out_b(out_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: plain array of architectural words.
   logic [BW-1:0] mdl [NR];
   logic [BW-1:0] snap [NR];

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit writable(input int a);
      return (a > 0) && (a < NR);
   endfunction

   // What a read port should show right now given the driven inputs.
   function automatic logic [BW-1:0] expect_rd(input int a);
      if (reset) return '0;
      if (!writable(a)) return '0;
`ifdef REGISTER_FILE_BYPASS_EN
      if (set && (int'(waddr) == a)) return in;
`endif
      return mdl[a];
   endfunction

   // Drive inputs on the falling edge, then check both ports against the model.
   task automatic step(input string tag, input logic rst, input logic st,
                       input int wa, input logic [BW-1:0] d, input int ra, input int rb);
      @(negedge clk);
      reset   = rst;
      set     = st;
      waddr   = AW'(wa);
      in      = d;
      raddr_a = AW'(ra);
      raddr_b = AW'(rb);
      if (rst) for (int i = 0; i < NR; i++) mdl[i] = '0;
      #1;
      chk({tag, "_a"}, out_a, expect_rd(ra));
      chk({tag, "_b"}, out_b, expect_rd(rb));
   endtask

   // Rising edge: commit the pending write into the model.
   task automatic tick();
      @(posedge clk);
      if (!reset && set && writable(int'(waddr))) mdl[int'(waddr)] = in;
   endtask

   initial begin
      reset = 1'b1; set = 1'b0; waddr = '0; in = '0; raddr_a = '0; raddr_b = '0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;

      // Reset state, including an attempted write while reset is held.
      step("rst0", 1, 1, 4, 32'hCAFEF00D, 4, 17); tick();
      chk("rst_const", out_a, 32'h0);
      step("rst_rel", 0, 0, 0, 0, 4, 23);         tick();
      chk("rst_wr_ignored", out_a, 32'h0);

      // Basic write/read on both ports.
      step("bw", 0, 1, 7, 32'h12345678, 1, 2);    tick();
      step("br", 0, 0, 0, 0, 7, 7);
      chk("basic_a", out_a, 32'h12345678);
      chk("basic_b", out_b, 32'h12345678);
      tick();
      step("b6", 0, 0, 0, 0, 6, 7);               tick();
      chk("word6_zero", out_a, 32'h0);

      // Reset mid-cycle, no clock edge needed.
      step("rcw", 0, 1, 5, 32'hDEADBEEF, 0, 0);   tick();
      step("rcr", 0, 0, 0, 0, 5, 7);
      chk("rc_before", out_a, 32'hDEADBEEF);
      #2 reset = 1'b1;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      #1 chk("rc_async", out_a, 32'h0);
      chk("rc_async_b", out_b, 32'h0);
      tick();
      step("rc_rel", 0, 0, 0, 0, 5, 7);           tick();
      chk("rc_stays0", out_a, 32'h0);

      // Same-cycle read/write conflict.
      step("cw", 0, 1, 3, 32'hAAAA0000, 0, 0);    tick();
      step("cc", 0, 1, 3, 32'h5555FFFF, 3, 1);
`ifdef REGISTER_FILE_BYPASS_EN
      chk("conf_pre", out_a, 32'h5555FFFF);
`else
      chk("conf_pre", out_a, 32'hAAAA0000);
`endif
      tick();
      step("cpost", 0, 0, 0, 0, 3, 3);            tick();
      chk("conf_post", out_a, 32'h5555FFFF);

      // Zero register, including the cycle a bypass would apply.
      step("zw", 0, 1, 0, 32'hFFFFFFFF, 0, 0);
      chk("zero_pre", out_a, 32'h0);
      tick();
      step("zr", 0, 0, 0, 0, 0, 0);               tick();
      chk("zero_post", out_a, 32'h0);

      // Out-of-range write/read.
      for (int i = 0; i < NR; i++) snap[i] = mdl[i];
      step("ow", 0, 1, 30, 32'h1, 30, 30);
      chk("oor_pre", out_b, 32'h0);
      tick();
      for (int i = 0; i < NR; i++) begin
         step("oor_scan", 0, 0, 0, 0, i, 30);     tick();
         chk("oor_word", out_a, snap[i]);
         chk("oor_rd", out_b, 32'h0);
      end

      // Back-to-back writes.
      step("bb1", 0, 1, 1, 32'h11, 1, 2);         tick();
      step("bb2", 0, 1, 2, 32'h22, 1, 2);
      chk("bb_w1_a", out_a, 32'h11);
      tick();
      step("bb3", 0, 0, 0, 0, 1, 2);
      chk("bb_w1_a2", out_a, 32'h11);
      chk("bb_w2_b", out_b, 32'h22);
      tick();

      // Randomized traffic with occasional reset pulses.
      for (int n = 0; n < 400; n++) begin
         int          wa, ra, rb;
         logic        st, rst;
         logic [BW-1:0] d;
         wa  = int'($urandom_range(0, 31));
         ra  = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 31));
         rb  = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 31));
         st  = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 39) == 0);
         d   = $urandom;
         step("rnd", rst, st, wa, d, ra, rb);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Parametrised multi-entry register file; successor to the single-word gate-level register in the register-file area of the data path.
- NUM_REGS words of BIT_WIDTH bits each.
- One synchronous write port and two independent combinational read ports.
- Serves as the architectural register store for the execute stage: operand A and B reads, one result writeback per cycle.

Parameters:
- BIT_WIDTH, 32, width of each stored word.
- NUM_REGS, 32, number of words; any value >= 2, not required to be a power of two.
- ZERO_REG, 1, when 1 word 0 is hardwired to zero; when 0 word 0 is an ordinary register.
- ADDR_WIDTH (localparam), $clog2(NUM_REGS), width of every address port.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- set  input  1  write enable for the write port.
- waddr  input  ADDR_WIDTH  write address.
- in  input  BIT_WIDTH  write data.
- raddr_a  input  ADDR_WIDTH  read port A address.
- raddr_b  input  ADDR_WIDTH  read port B address.
- out_a  output  BIT_WIDTH  read port A data.
- out_b  output  BIT_WIDTH  read port B data.

Behaviour:
- Reset:
  - reset high clears every word to 0 immediately, with no clock edge required.
  - While reset is high, out_a and out_b are 0 for any address.
  - Writes with set=1 are ignored while reset is high.
- Write:
  - On the rising clk edge with reset low and set=1, word[waddr] <= in.
  - The new value is visible on the read ports from the following cycle; write latency is 1 cycle.
  - set=0 leaves all words unchanged.
- Read:
  - Purely combinational: out_a = word[raddr_a], out_b = word[raddr_b]; read latency is 0 cycles.
  - Both ports may address the same word simultaneously; each returns the same data.
- Same-cycle read/write to the same address (no bypass): the read returns the old contents during that cycle and the new contents after the edge.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0.
  - This overrides the bypass.
- Out-of-range addresses (address >= NUM_REGS, possible when NUM_REGS is not a power of two):
  - A write is discarded.
  - A read returns 0.
- Reset asserted mid-operation: any write in flight on that edge is lost, and all words read 0 until the first write after reset deasserts.
- Reset deassertion: synchronous release is the responsibility of the top-level reset synchroniser; the block requires nothing further.

Optional Feature:
- Macro REGISTER_FILE_BYPASS_EN.
- When defined:
  - A read port whose address equals waddr while set=1, reset=0, and the address is valid and writable returns in combinationally in the same cycle (write-through bypass).
  - Applies independently to each read port.
  - Bypass never applies to address 0 when ZERO_REG=1.
- When not defined: reads always return stored contents, with the old-value semantics described under Behaviour.
- The storage update timing is identical in both builds.

Test Plan:
- Reset clear: write 0xDEADBEEF to word 5, assert reset mid-cycle with no clock edge -> out_a (raddr_a=5) reads 0x00000000 immediately; stays 0 after release until rewritten.
- Basic write/read: set=1, waddr=7, in=0x12345678, one edge, then set=0 -> out_a (raddr_a=7) = 0x12345678 and out_b (raddr_b=7) = 0x12345678; word 6 still 0.
- Same-cycle conflict: word 3 = 0xAAAA0000; in the same cycle set=1, waddr=3, in=0x5555FFFF, raddr_a=3:
  - Without macro: out_a = 0xAAAA0000 before the edge and 0x5555FFFF after it.
  - With REGISTER_FILE_BYPASS_EN: out_a = 0x5555FFFF before the edge.
- Zero register: ZERO_REG=1, write 0xFFFFFFFF to address 0 -> out_a (raddr_a=0) = 0 in all builds, including the bypass cycle.
- Out-of-range: NUM_REGS=24, write 0x1 to address 30 -> no word changes (check words 0-23); out_b (raddr_b=30) = 0.
- Back-to-back writes: write 0x11 to word 1 then 0x22 to word 2 on consecutive edges, reading word 1 on port A and word 2 on port B each cycle -> each value appears exactly one cycle after its write edge; no cross-corruption.
